// File: rtl/gpu_mem_pkg.sv
// Shared types and constants for the image memory arbiter.
//   LANES / AW / DW : geometry of the 3-lane image RAM
//   lane_addr_t     : one address per lane
//   lane_data_t     : one data word per lane
//   req_id_t        : requester index, wide enough for up to 4 requesters
//   arb_state_e     : arbiter FSM states
//   wrap_inc        : round-robin pointer increment modulo the requester count
package gpu_mem_pkg;

    localparam int LANES = 3;
    localparam int AW    = 10;
    localparam int DW    = 18;
    localparam int ID_W  = 2;

    typedef logic [LANES-1:0][AW-1:0] lane_addr_t;
    typedef logic [LANES-1:0][DW-1:0] lane_data_t;
    typedef logic [ID_W-1:0]          req_id_t;

    typedef enum logic {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    function automatic req_id_t wrap_inc(input req_id_t id, input int n);
        req_id_t r;
        if (int'(id) + 1 >= n) begin
            r = '0;
        end else begin
            r = id + req_id_t'(1);
        end
        return r;
    endfunction

endpackage

// File: rtl/image_mem_arbiter_rr_pick.sv
// Combinational round-robin picker.
//   req : request vector
//   ptr : highest-priority requester this cycle
//   gnt : one-hot winner (zero when nobody requests)
//   id  : index of the winner
//   any : at least one request present
module rr_pick
    import gpu_mem_pkg::*;
#(
    parameter int NREQ = 3
) (
    input  logic [NREQ-1:0] req,
    input  req_id_t         ptr,
    output logic [NREQ-1:0] gnt,
    output req_id_t         id,
    output logic            any
);

    always_comb begin
        int idx;
        idx = 0;
        gnt = '0;
        id  = '0;
        any = 1'b0;
        // Scan ptr, ptr+1, ... and keep only the first hit.
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (!any && req[idx]) begin
                any      = 1'b1;
                gnt[idx] = 1'b1;
                id       = req_id_t'(idx);
            end
        end
    end

endmodule

// File: rtl/image_mem_arbiter.sv
// Arbiter sharing the 3-lane image RAM between NREQ requesters
// (0 = filterGPU core, 1 = image loader, 2 = display reader).
//   CLK, RST        : clock, asynchronous active-low reset
//   req/lock/we     : per-requester request, locked-burst request, write flag
//   addr/wdata      : per-requester lane addresses and write data
//   gnt             : one-hot beat accepted this cycle (combinational)
//   rvalid/rdata    : read response, rvalid[i] MEM_LAT cycles after the grant
//   gpu_stall       : core is requesting but not granted
//   mem_*           : RAM port, driven by the winner (zero when idle)
//
// Handshake: a beat transfers in any cycle where req[i] and gnt[i] are both
// high; requesters hold addr/wdata/we stable until granted and may drop req
// before a grant without side effects.
module image_mem_arbiter
    import gpu_mem_pkg::*;
#(
    parameter int NREQ      = 3,
    parameter int MEM_LAT   = 1,
    parameter int MAX_BURST = 16
) (
    input  logic                              CLK,
    input  logic                              RST,
    input  logic [NREQ-1:0]                   req,
    input  logic [NREQ-1:0]                   lock,
    input  logic [NREQ-1:0]                   we,
    input  logic [NREQ-1:0][LANES-1:0][AW-1:0] addr,
    input  logic [NREQ-1:0][LANES-1:0][DW-1:0] wdata,
    output logic [NREQ-1:0]                   gnt,
    output logic [NREQ-1:0]                   rvalid,
    output logic [LANES-1:0][DW-1:0]          rdata,
    output logic                              gpu_stall,
    output logic                              mem_we,
    output logic [LANES-1:0][AW-1:0]          mem_addr,
    output logic [LANES-1:0][DW-1:0]          mem_wdata,
    input  logic [LANES-1:0][DW-1:0]          mem_rdata
);

    localparam int CW = $clog2(MAX_BURST + 1);

    arb_state_e    state_q, state_d;
    req_id_t       ptr_q, ptr_d;
    req_id_t       owner_q, owner_d;
    logic [CW-1:0] burst_cnt_q, burst_cnt_d;

    logic [MEM_LAT-1:0]          pipe_vld_q, pipe_vld_d;
    req_id_t [MEM_LAT-1:0]       pipe_id_q, pipe_id_d;

    logic [NREQ-1:0] pick_gnt;
    req_id_t         pick_id;
    logic            pick_any;

    logic [NREQ-1:0] gnt_raw;
    req_id_t         win_id;
    logic            beat;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req (req),
        .ptr (ptr_q),
        .gnt (pick_gnt),
        .id  (pick_id),
        .any (pick_any)
    );

    // Grant selection: round-robin in ARB, owner-only in LOCKED.
    always_comb begin
        gnt_raw = '0;
        win_id  = '0;
        if (state_q == ARB) begin
            gnt_raw = pick_gnt;
            win_id  = pick_id;
        end else begin
            gnt_raw[owner_q] = req[owner_q];
            win_id           = owner_q;
        end
    end

    // Outputs are forced quiet while reset is asserted, even though gnt is
    // combinational from req.
    assign gnt       = RST ? gnt_raw : '0;
    assign beat      = |gnt;
    assign gpu_stall = RST & req[0] & ~gnt[0];
    assign mem_we    = beat & we[win_id];
    assign mem_addr  = beat ? addr[win_id]  : '0;
    assign mem_wdata = beat ? wdata[win_id] : '0;
    assign rdata     = mem_rdata;

    // FSM next state.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        burst_cnt_d = burst_cnt_q;
        case (state_q)
            ARB: begin
                if (pick_any) begin
                    // A single-beat cap makes a locked request an ordinary beat.
                    if (lock[pick_id] && (MAX_BURST > 1)) begin
                        state_d     = LOCKED;
                        owner_d     = pick_id;
                        burst_cnt_d = CW'(1);
                    end else begin
                        ptr_d = wrap_inc(pick_id, NREQ);
                    end
                end
            end
            LOCKED: begin
                if (req[owner_q] && lock[owner_q]
                    && (int'(burst_cnt_q) + 1 < MAX_BURST)) begin
                    burst_cnt_d = burst_cnt_q + CW'(1);
                end else begin
                    // Last beat, cap reached, or owner went away (bubble).
                    state_d     = ARB;
                    ptr_d       = wrap_inc(owner_q, NREQ);
                    burst_cnt_d = '0;
                end
            end
            default: begin
                state_d     = ARB;
                burst_cnt_d = '0;
            end
        endcase
    end

    // Read-response shift pipe: one stage per cycle of RAM latency.
    always_comb begin
        pipe_vld_d    = pipe_vld_q;
        pipe_id_d     = pipe_id_q;
        pipe_vld_d[0] = beat & ~we[win_id];
        pipe_id_d[0]  = win_id;
        for (int k = 1; k < MEM_LAT; k++) begin
            pipe_vld_d[k] = pipe_vld_q[k-1];
            pipe_id_d[k]  = pipe_id_q[k-1];
        end
    end

    always_comb begin
        rvalid = '0;
        rvalid[pipe_id_q[MEM_LAT-1]] = pipe_vld_q[MEM_LAT-1];
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= ARB;
            ptr_q       <= '0;
            owner_q     <= '0;
            burst_cnt_q <= '0;
            pipe_vld_q  <= '0;
            pipe_id_q   <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            burst_cnt_q <= burst_cnt_d;
            pipe_vld_q  <= pipe_vld_d;
            pipe_id_q   <= pipe_id_d;
        end
    end

endmodule
